noc_link_pipe: RTL and testbench
================================

NOC_LINK_PIPE -- requirements
Module: noc_link_pipe

Interface
REQ-001 SHALL have parameter FLIT_W, default 64: flit payload width in bits.
REQ-002 SHALL have parameter VC_NUM, default 2: number of virtual channels; legal range 1..8.
REQ-003 SHALL have parameter DEPTH, default 2: number of pipeline stages; legal range 1..8.
REQ-004 SHALL define VC_W = max(1, $clog2(VC_NUM)) as a local parameter.
REQ-005 noc_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 noc_rst  in  1  reset; synchronous, active-high.
REQ-007 s_valid  in  1  upstream flit valid.
REQ-008 s_ready  out  1  pipe accepts the flit presented this cycle.
REQ-009 s_vc  in  VC_W  VC id of the upstream flit.
REQ-010 s_flit  in  FLIT_W  upstream flit payload.
REQ-011 s_vc_ready  out  VC_NUM  per-VC credit, returned to the upstream sender.
REQ-012 m_valid  out  1  downstream flit valid.
REQ-013 m_ready  in  1  downstream accepts the flit.
REQ-014 m_vc  out  VC_W  VC id of the downstream flit.
REQ-015 m_flit  out  FLIT_W  downstream flit payload.
REQ-016 m_vc_ready  in  VC_NUM  per-VC credit from the downstream router.
REQ-017 link_idle  out  1  high when every stage holds zero flits.

Function
REQ-018 Transfer rules: a transfer occurs on valid&&ready at a clock edge; no combinational path from m_ready to s_ready.
REQ-019 Each stage SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO:
- EMPTY goes to ONE on push.
- ONE goes to TWO on push without pop.
- ONE goes to EMPTY on pop without push.
- ONE stays ONE on simultaneous push and pop.
- TWO goes to ONE on pop.
REQ-020 A stage's ready output SHALL be registered and high exactly when the stage is not in state TWO.
REQ-021 Latency and throughput: a flit accepted at edge t SHALL appear on m_valid at edge t+DEPTH when no stage is stalled; sustained throughput is 1 flit per cycle.
REQ-022 Flits and their VC ids SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 While m_valid is high and m_ready is low, m_valid, m_vc and m_flit SHALL hold stable.
REQ-024 Full-pipe behaviour: with m_ready held low, the pipe SHALL absorb exactly 2*DEPTH flits, then drive s_ready low.
REQ-025 Credit path: s_vc_ready SHALL equal m_vc_ready delayed by exactly DEPTH cycles through a shift register.
REQ-026 Credit slack: downstream VC buffers provide 2*DEPTH entries of slack; this is a system requirement and the block does not check it.
REQ-027 link_idle SHALL be registered and SHALL be high iff all stages are EMPTY.

Reset
REQ-028 With noc_rst high at an edge, the block SHALL reset as follows:
- all stages go to EMPTY;
- m_valid=0, m_vc=0, m_flit=0;
- s_ready=0, s_vc_ready=0;
- link_idle=1.
REQ-029 s_ready SHALL rise one cycle after noc_rst falls; s_vc_ready SHALL stay 0 until the first credit sampled after reset has propagated through DEPTH stages.
REQ-030 Reset asserted mid-transfer SHALL discard every in-flight flit, and no partial flit may appear afterwards.

Configuration
REQ-031 Macro NOC_LINK_PIPE_STATS_EN defined: the block SHALL add the following:
- input stat_clr (1 bit);
- outputs stat_flit_cnt (32 bits) and stat_stall_cnt (32 bits).
REQ-032 Counter behaviour under NOC_LINK_PIPE_STATS_EN:
- stat_flit_cnt increments on each m_valid&&m_ready.
- stat_stall_cnt increments on each m_valid&&!m_ready.
- Both counters saturate at all-ones.
- stat_clr clears both counters synchronously; stat_clr wins over a same-cycle increment.
- noc_rst clears both counters.
REQ-033 Macro undefined: the three stats ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 DEPTH=2, m_ready=1: push flits 0xA1..0xA4 on VCs 0,1,0,1 on consecutive cycles -> m_flit shows 0xA1 at t+2, then one flit per cycle with matching m_vc.
REQ-035 DEPTH=3, m_ready=0, s_valid=1 continuously -> exactly 6 flits accepted, then s_ready=0; set m_ready=1 -> 6 flits drain in order, then link_idle=1.
REQ-036 Random s_valid and m_ready at 50% each, 10000 flits -> scoreboard shows no loss or reorder, and m_flit holds stable on every stalled cycle.
REQ-037 m_vc_ready toggles 2'b01 then 2'b10 with DEPTH=4 -> s_vc_ready follows the same pattern exactly 4 cycles later.
REQ-038 noc_rst pulsed for 1 cycle with 3 flits in flight -> next cycle m_valid=0 and link_idle=1, and no stale flit is ever emitted.
REQ-039 NOC_LINK_PIPE_STATS_EN defined: 5 transfers plus 3 stall cycles -> stat_flit_cnt=5 and stat_stall_cnt=3; stat_clr asserted together with a transfer -> both counters read 0.

Source files
------------

// File: rtl/noc_link_pipe.sv
// NoC link pipeline: DEPTH chained 2-entry skid stages carrying {vc, flit}, plus a DEPTH-deep credit delay line; optional counters under NOC_LINK_PIPE_STATS_EN.
// Latency: DEPTH cycles from acceptance to m_valid when unstalled; 1 flit/cycle sustained; credits delayed exactly DEPTH cycles.
// Backpressure: each stage's ready is registered (high unless the stage holds two flits), so m_ready never reaches s_ready combinationally.
module noc_link_pipe #(
    parameter int FLIT_W = 64,
    parameter int VC_NUM = 2,
    parameter int DEPTH  = 2,
    localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [VC_W-1:0]   s_vc,
    input  logic [FLIT_W-1:0] s_flit,
    output logic [VC_NUM-1:0] s_vc_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [VC_W-1:0]   m_vc,
    output logic [FLIT_W-1:0] m_flit,
    input  logic [VC_NUM-1:0] m_vc_ready,
    output logic              link_idle
`ifdef NOC_LINK_PIPE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_flit_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    localparam int EW = VC_W + FLIT_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state     [DEPTH];
    state_t              w_state_nxt [DEPTH];
    logic   [EW-1:0]     r_head      [DEPTH];
    logic   [EW-1:0]     r_skid      [DEPTH];
    logic   [EW-1:0]     w_in_dat    [DEPTH];
    logic   [DEPTH-1:0]  r_rdy;
    logic   [DEPTH-1:0]  w_in_vld;
    logic   [DEPTH-1:0]  w_out_vld;
    logic   [DEPTH-1:0]  w_out_rdy;
    logic   [DEPTH-1:0]  w_push;
    logic   [DEPTH-1:0]  w_pop;
    logic                w_all_empty;
    logic                r_idle;
    logic   [VC_NUM-1:0] r_cred      [DEPTH];

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_link
            assign w_out_vld[g] = (r_state[g] != ST_EMPTY);
            if (g == 0) begin : g_first
                assign w_in_vld[g] = s_valid;
                assign w_in_dat[g] = {s_vc, s_flit};
            end else begin : g_mid
                assign w_in_vld[g] = w_out_vld[g-1];
                assign w_in_dat[g] = r_head[g-1];
            end
            if (g == DEPTH - 1) begin : g_last
                assign w_out_rdy[g] = m_ready;
            end else begin : g_inner
                assign w_out_rdy[g] = r_rdy[g+1];
            end
        end
    endgenerate

    always_comb begin
        w_push      = '0;
        w_pop       = '0;
        w_all_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w_push[i]      = w_in_vld[i] && r_rdy[i];
            w_pop[i]       = w_out_vld[i] && w_out_rdy[i];
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_EMPTY: if (w_push[i]) w_state_nxt[i] = ST_ONE;
                ST_ONE: begin
                    if (w_push[i] && !w_pop[i])      w_state_nxt[i] = ST_TWO;
                    else if (!w_push[i] && w_pop[i]) w_state_nxt[i] = ST_EMPTY;
                end
                ST_TWO:   if (w_pop[i]) w_state_nxt[i] = ST_ONE;
                default:  w_state_nxt[i] = ST_EMPTY;
            endcase
            if (w_state_nxt[i] != ST_EMPTY) w_all_empty = 1'b0;
        end
    end

    // Head always holds the oldest flit; skid only fills when the stage is blocked downstream.
    always_ff @(posedge noc_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (noc_rst) begin
                r_state[i] <= ST_EMPTY;
                r_head[i]  <= '0;
                r_skid[i]  <= '0;
                r_rdy[i]   <= 1'b0;
            end else begin
                r_state[i] <= w_state_nxt[i];
                r_rdy[i]   <= (w_state_nxt[i] != ST_TWO);
                case (r_state[i])
                    ST_EMPTY: if (w_push[i]) r_head[i] <= w_in_dat[i];
                    ST_ONE: begin
                        if (w_push[i] && w_pop[i]) r_head[i] <= w_in_dat[i];
                        else if (w_push[i])        r_skid[i] <= w_in_dat[i];
                    end
                    ST_TWO:   if (w_pop[i]) r_head[i] <= r_skid[i];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= w_all_empty;
        end
    end

    always_ff @(posedge noc_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (noc_rst) begin
                r_cred[i] <= '0;
            end else if (i == 0) begin
                r_cred[i] <= m_vc_ready;
            end else begin
                r_cred[i] <= r_cred[(i > 0) ? i - 1 : 0];
            end
        end
    end

    assign s_ready        = r_rdy[0];
    assign m_valid        = w_out_vld[DEPTH-1];
    assign {m_vc, m_flit} = r_head[DEPTH-1];
    assign s_vc_ready     = r_cred[DEPTH-1];
    assign link_idle      = r_idle;

`ifdef NOC_LINK_PIPE_STATS_EN
    logic [31:0] r_flit_cnt;
    logic [31:0] r_stall_cnt;

    // Clear dominates any same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge noc_clk) begin
        if (noc_rst || stat_clr) begin
            r_flit_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (m_valid && m_ready && (r_flit_cnt != '1))
                r_flit_cnt <= r_flit_cnt + 32'd1;
            if (m_valid && !m_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stat_flit_cnt  = r_flit_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_noc_link_pipe.sv
// Bench for noc_link_pipe: queue-based reference model of an in-order link with DEPTH-cycle latency,
// 2*DEPTH flit capacity and a DEPTH-cycle credit delay; monitors compare independently of the stimulus.
module tb_noc_link_pipe;
    localparam int FLIT_W = 16;
    localparam int VC_NUM = 2;
    localparam int DEPTH  = 3;
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic              noc_clk    = 1'b0;
    logic              noc_rst    = 1'b1;
    logic              s_valid    = 1'b0;
    logic              m_ready    = 1'b0;
    logic [VC_W-1:0]   s_vc       = '0;
    logic [FLIT_W-1:0] s_flit     = '0;
    logic [VC_NUM-1:0] m_vc_ready = '0;
    logic              s_ready;
    logic [VC_NUM-1:0] s_vc_ready;
    logic              m_valid;
    logic [VC_W-1:0]   m_vc;
    logic [FLIT_W-1:0] m_flit;
    logic              link_idle;
`ifdef NOC_LINK_PIPE_STATS_EN
    logic              stat_clr = 1'b0;
    logic [31:0]       stat_flit_cnt;
    logic [31:0]       stat_stall_cnt;
`endif

    noc_link_pipe #(.FLIT_W(FLIT_W), .VC_NUM(VC_NUM), .DEPTH(DEPTH)) dut (
        .noc_clk    (noc_clk),
        .noc_rst    (noc_rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_vc       (s_vc),
        .s_flit     (s_flit),
        .s_vc_ready (s_vc_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_vc       (m_vc),
        .m_flit     (m_flit),
        .m_vc_ready (m_vc_ready),
        .link_idle  (link_idle)
`ifdef NOC_LINK_PIPE_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_flit_cnt (stat_flit_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [VC_W-1:0]   vc;
        logic [FLIT_W-1:0] flit;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [VC_NUM-1:0] cq[$];
    int                n_chk   = 0;
    int                n_pass  = 0;
    int                cyc     = 0;
    int                n_acc   = 0;
    bit                lat_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    always @(posedge noc_clk) cyc <= cyc + 1;

    // Input side of the model: every accepted flit is expected later, in order.
    always @(negedge noc_clk) begin
        exp_t e;
        if (noc_rst) begin
            sb.delete();
        end else if (s_valid && s_ready) begin
            e.vc   = s_vc;
            e.flit = s_flit;
            e.cyc  = cyc;
            sb.push_back(e);
            n_acc++;
        end
    end

    logic              prev_stall = 1'b0;
    logic [VC_W-1:0]   prev_vc    = '0;
    logic [FLIT_W-1:0] prev_flit  = '0;

    always @(negedge noc_clk) begin
        exp_t e;
        if (noc_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_vc",    64'(m_vc),    64'(prev_vc));
                chk("hold_flit",  64'(m_flit),  64'(prev_flit));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_flit: got flit %0h vc %0h, required no flit", m_flit, m_vc);
                end else begin
                    e = sb.pop_front();
                    chk("out_vc",   64'(m_vc),   64'(e.vc));
                    chk("out_flit", 64'(m_flit), 64'(e.flit));
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(DEPTH));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_vc    = m_vc;
            prev_flit  = m_flit;
        end
    end

    // Credit model: a FIFO pre-loaded with DEPTH zero words after reset.
    always @(negedge noc_clk) begin
        logic [VC_NUM-1:0] ce;
        if (noc_rst) begin
            cq.delete();
            for (int i = 0; i < DEPTH; i++) cq.push_back('0);
        end else begin
            ce = cq.pop_front();
            chk("credit", 64'(s_vc_ready), 64'(ce));
            cq.push_back(m_vc_ready);
        end
    end

    task automatic push(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] f);
        int w = 0;
        s_valid = 1'b1;
        s_vc    = vc;
        s_flit  = f;
        @(negedge noc_clk);
        while (!s_ready && w < 100) begin
            @(negedge noc_clk);
            w++;
        end
        if (w >= 100) begin
            n_chk++;
            $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", w);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        @(negedge noc_clk);
        while (!link_idle && w < 200) begin
            @(negedge noc_clk);
            w++;
        end
        chk(name, 64'(link_idle), 64'd1);
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w;

        noc_rst = 1'b1;
        repeat (3) tick();
        @(negedge noc_clk);
        chk("rst_s_ready",    64'(s_ready),    64'd0);
        chk("rst_m_valid",    64'(m_valid),    64'd0);
        chk("rst_m_vc",       64'(m_vc),       64'd0);
        chk("rst_m_flit",     64'(m_flit),     64'd0);
        chk("rst_link_idle",  64'(link_idle),  64'd1);
        chk("rst_s_vc_ready", 64'(s_vc_ready), 64'd0);
        tick();
        noc_rst    = 1'b0;
        m_vc_ready = 2'b11;
        @(negedge noc_clk);
        chk("s_ready_first_cycle", 64'(s_ready), 64'd0);
        tick();
        @(negedge noc_clk);
        chk("s_ready_rise", 64'(s_ready), 64'd1);
        tick();

        // In-order flits with fixed latency on an unstalled link.
        m_ready = 1'b1;
        lat_chk = 1'b1;
        push(1'b0, 16'h00A1);
        push(1'b1, 16'h00A2);
        push(1'b0, 16'h00A3);
        push(1'b1, 16'h00A4);
        wait_idle("directed_idle");
        lat_chk = 1'b0;

        // Full pipe: exactly 2*DEPTH flits absorbed while blocked.
        m_ready = 1'b0;
        base    = n_acc;
        s_valid = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 6; k++) begin
            s_vc   = VC_W'($urandom_range(0, VC_NUM - 1));
            s_flit = FLIT_W'($urandom);
            tick();
        end
        s_valid = 1'b0;
        @(negedge noc_clk);
        chk("full_absorb",    64'(n_acc - base), 64'(2 * DEPTH));
        chk("full_s_ready",   64'(s_ready),      64'd0);
        chk("full_link_busy", 64'(link_idle),    64'd0);
        tick();
        m_ready = 1'b1;
        wait_idle("drain_idle");
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with flits in flight: everything is discarded.
        m_ready = 1'b0;
        push(1'b1, 16'h0B01);
        push(1'b0, 16'h0B02);
        push(1'b1, 16'h0B03);
        noc_rst = 1'b1;
        tick();
        noc_rst = 1'b0;
        m_ready = 1'b1;
        @(negedge noc_clk);
        chk("midrst_m_valid",   64'(m_valid),   64'd0);
        chk("midrst_link_idle", 64'(link_idle), 64'd1);
        chk("midrst_s_ready",   64'(s_ready),   64'd0);
        tick();
        @(negedge noc_clk);
        chk("midrst_s_ready_rise", 64'(s_ready), 64'd1);
        tick();
        repeat (20) tick();

        // Credit line with an alternating pattern.
        for (int k = 0; k < 30; k++) begin
            m_vc_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
        end

        // Random traffic on both sides.
        base = n_acc;
        w    = 0;
        while ((n_acc - base) < 10000 && w < 60000) begin
            s_valid    = 1'($urandom_range(0, 1));
            s_vc       = VC_W'($urandom_range(0, VC_NUM - 1));
            s_flit     = FLIT_W'($urandom);
            m_ready    = 1'($urandom_range(0, 1));
            m_vc_ready = VC_NUM'($urandom);
            tick();
            w++;
        end
        s_valid = 1'b0;
        if (w >= 60000) begin
            n_chk++;
            $display("FAIL random_timeout: accepted %0d flits, required 10000", n_acc - base);
        end
        m_ready = 1'b1;
        wait_idle("random_idle");
        chk("random_sb_empty", 64'(sb.size()), 64'd0);

`ifdef NOC_LINK_PIPE_STATS_EN
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(VC_W'(k % VC_NUM), FLIT_W'(16'h0C00 + k));
        repeat (8) tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        repeat (3) tick();
        m_ready = 1'b1;
        wait_idle("stats_idle");
        @(negedge noc_clk);
        chk("stat_flit_cnt",  64'(stat_flit_cnt),  64'd5);
        chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'd3);
        tick();
        m_ready = 1'b0;
        push(1'b1, 16'h0CFF);
        w = 0;
        @(negedge noc_clk);
        while (!m_valid && w < 50) begin
            @(negedge noc_clk);
            w++;
        end
        tick();
        m_ready  = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge noc_clk);
        chk("clr_flit_cnt",  64'(stat_flit_cnt),  64'd0);
        chk("clr_stall_cnt", 64'(stat_stall_cnt), 64'd0);
        tick();
`endif

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
